adc_frame_snapshot: RTL and testbench
=====================================

Name: adc_frame_snapshot

Overview:
- Sits directly downstream of adc_streaming_ingest and consumes its FIFO pop interface (valid/ready, 32-bit words).
- Groups consecutive words into frames of NUM_CH words; word i of a frame belongs to channel i.
- Each complete frame is committed atomically to a visible per-channel snapshot bank, which firmware reads through an indexed read port.
- Frame and drop counters support host-side monitoring.

Parameters:
NUM_CH, 3, words per frame / channels per snapshot (1..16)
CH_IDX_W, 4, width of rd_ch; must satisfy 2^CH_IDX_W >= NUM_CH
DATA_BITS, 24, valid LSBs of each input word (1..32)
SIGN_EXTEND, 1, 1 = sign-extend bit DATA_BITS-1 into [31:DATA_BITS]; 0 = zero-fill

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
enable  in  1  allows consumption of input words
resync  in  1  discard any partial frame; realign to word 0
hold  in  1  freeze snapshot bank; completed frames are dropped, not committed
in_valid  in  1  word available (from ingest pop_valid)
in_data  in  32  word (from ingest pop_data)
in_ready  out  1  accept (to ingest pop_ready)
rd_ch  in  CH_IDX_W  channel select for read port
rd_data  out  32  registered snapshot value of rd_ch
frame_count  out  32  committed frames, wraps modulo 2^32
frames_dropped  out  16  frames completed while hold=1, saturating at 0xFFFF
frame_done  out  1  one-cycle pulse, the cycle after a commit
partial  out  1  1 while word index != 0

Behaviour:
- Clocking and reset:
  - Single clock; all state updates on posedge clk.
  - rst is synchronous and active-high, and overrides everything.
  - Reset values: visible bank = 0, shadow bank = 0, word index = 0, rd_data = 0, frame_count = 0, frames_dropped = 0, frame_done = 0, partial = 0.
- Handshake:
  - in_ready = enable & ~resync & ~rst (combinational).
  - A word is accepted on any cycle with in_valid & in_ready.
  - Acceptance is never stalled for any other reason. The block always drains.
- Extension: ext = in_data[DATA_BITS-1:0] extended to 32 bits per SIGN_EXTEND. When DATA_BITS = 32, ext = in_data.
- Accept with idx < NUM_CH-1: shadow[idx] <= ext; idx <= idx+1.
- Accept with idx == NUM_CH-1 (frame complete): idx <= 0, then:
  - hold=0 (commit), same edge:
    - visible[i] <= shadow[i] for i < NUM_CH-1;
    - visible[NUM_CH-1] <= ext;
    - frame_count <= frame_count+1;
    - frame_done = 1 on the next cycle only.
  - hold=1: visible bank unchanged; frames_dropped <= min(frames_dropped+1, 0xFFFF); no frame_done.
- NUM_CH = 1: every accepted word completes a frame.
- resync=1: idx <= 0; shadow contents are left untouched (they get overwritten). Because in_ready=0 while resync=1, no word is consumed in that cycle.
- enable=0 mid-frame: idx and shadow are retained; the frame resumes when enable returns.
- hold changing mid-frame: only the hold value on the completing cycle matters.
- partial is registered: partial = (idx != 0) after each edge.
- Read port:
  - rd_data <= (rd_ch < NUM_CH) ? visible[rd_ch] : 0.
  - Latency is 1 cycle.
  - A read sampled on the commit edge returns the pre-commit value; the new value is visible one cycle later.
- Sequential state: idx counter, shadow bank, visible bank, frame_done pulse register, counters, rd_data register. No hidden FSM beyond idx.

Test Plan:
- Basic commit: NUM_CH=3, DATA_BITS=24, SIGN_EXTEND=1, enable=1. Feed 0x00123456, 0x00800001, 0x007FFFFF. Required:
  - visible = 0x00123456, 0xFF800001, 0x007FFFFF;
  - frame_count=1; frame_done high exactly 1 cycle after the 3rd accept;
  - rd_ch=3 returns 0.
- Zero-fill variant: same stimulus with SIGN_EXTEND=0 -> ch1 reads 0x00800001. Back-to-back continuous valid for 4 frames -> frame_count=4, in_ready held at 1 throughout, partial toggles correctly.
- Hold/drop: hold=1 across 2 complete frames -> visible unchanged from the prior frame, frames_dropped=2, no frame_done. Release hold, send 1 frame -> commit, frame_count increments by 1. Saturation: preload 0xFFFF drops (or force) and complete one more -> stays 0xFFFF.
- Resync mid-frame: accept 2 words, pulse resync with in_valid=1 -> in_ready=0 that cycle, partial=0 after. Next 3 words form a clean frame and commit them exactly.
- Enable gap and reset: accept 1 word, enable=0 for 10 cycles (in_ready=0, idx held), then 2 more words -> commit. Separately, assert rst mid-frame -> all outputs 0, and the next 3 words form frame 1.
- Read timing: hold rd_ch=0 and commit a new frame -> rd_data shows the old value on the commit edge and the new value one cycle later.

Source files
------------

// File: rtl/adc_frame_snapshot.sv
// Groups ingest FIFO words into NUM_CH-word frames and commits each complete
// frame atomically into a firmware-visible per-channel snapshot bank.
module adc_frame_snapshot #(
   parameter int unsigned NUM_CH      = 3,
   parameter int unsigned CH_IDX_W    = 4,
   parameter int unsigned DATA_BITS   = 24,
   parameter int unsigned SIGN_EXTEND = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic                resync,
   input  logic                hold,
   input  logic                in_valid,
   input  logic [31:0]         in_data,
   output logic                in_ready,
   input  logic [CH_IDX_W-1:0] rd_ch,
   output logic [31:0]         rd_data,
   output logic [31:0]         frame_count,
   output logic [15:0]         frames_dropped,
   output logic                frame_done,
   output logic                partial
);

   localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] idx_nxt;
   logic [31:0]      shadow  [NUM_CH];
   logic [31:0]      visible [NUM_CH];
   logic [31:0]      ext;
   logic             accept;
   logic             frame_end;
   logic             rd_hit;
   logic [IDX_W-1:0] rd_sel;

   assign in_ready  = enable & ~resync & ~rst;
   assign accept    = in_valid & in_ready;
   assign frame_end = accept & (idx == LAST_IDX);
   assign rd_hit    = (32'(rd_ch) < NUM_CH);
   assign rd_sel    = IDX_W'(rd_ch);

   // Widen the valid sample bits to a full word (sign-extend or zero-fill).
   always_comb begin
      ext = in_data;
      for (int unsigned b = DATA_BITS; b < 32; b++) begin
         ext[b] = (SIGN_EXTEND != 0) ? in_data[DATA_BITS-1] : 1'b0;
      end
   end

   // Word index within the current frame; resync realigns to word 0.
   always_comb begin
      idx_nxt = idx;
      if (resync) begin
         idx_nxt = '0;
      end else if (frame_end) begin
         idx_nxt = '0;
      end else if (accept) begin
         idx_nxt = idx + IDX_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx            <= '0;
         partial        <= 1'b0;
         frame_done     <= 1'b0;
         frame_count    <= '0;
         frames_dropped <= '0;
         rd_data        <= '0;
         for (int i = 0; i < int'(NUM_CH); i++) begin
            shadow[i]  <= '0;
            visible[i] <= '0;
         end
      end else begin
         idx        <= idx_nxt;
         partial    <= (idx_nxt != '0);
         frame_done <= frame_end & ~hold;
         rd_data    <= rd_hit ? visible[rd_sel] : 32'd0;

         if (accept && !frame_end) begin
            shadow[idx] <= ext;
         end

         // Last word bypasses the shadow so the whole frame lands on one edge.
         if (frame_end) begin
            if (!hold) begin
               for (int i = 0; i < int'(NUM_CH) - 1; i++) begin
                  visible[i] <= shadow[i];
               end
               visible[NUM_CH-1] <= ext;
               frame_count       <= frame_count + 32'd1;
            end else if (frames_dropped != 16'hFFFF) begin
               frames_dropped <= frames_dropped + 16'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_adc_frame_snapshot.sv
// Randomized self-checking bench for adc_frame_snapshot against a queue-based
// frame model; a NUM_CH=1 instance covers drop-counter saturation.
module tb_adc_frame_snapshot;

   localparam int unsigned NCH = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, enable, resync, hold, in_valid;
   logic [31:0] in_data;
   logic [3:0]  rd_ch;

   logic        in_ready, frame_done, partial;
   logic [31:0] rd_data, frame_count;
   logic [15:0] frames_dropped;

   logic        z_in_ready, z_frame_done, z_partial;
   logic [31:0] z_rd_data, z_frame_count;
   logic [15:0] z_frames_dropped;

   logic        s_enable, s_resync, s_hold, s_valid;
   logic [31:0] s_data;
   logic [3:0]  s_rd_ch;
   logic        s_in_ready, s_frame_done, s_partial;
   logic [31:0] s_rd_data, s_frame_count;
   logic [15:0] s_frames_dropped;

   adc_frame_snapshot #(.NUM_CH(3), .CH_IDX_W(4), .DATA_BITS(24), .SIGN_EXTEND(1)) u_sx (
      .clk(clk), .rst(rst), .enable(enable), .resync(resync), .hold(hold),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .rd_ch(rd_ch),
      .rd_data(rd_data), .frame_count(frame_count), .frames_dropped(frames_dropped),
      .frame_done(frame_done), .partial(partial));

   adc_frame_snapshot #(.NUM_CH(3), .CH_IDX_W(4), .DATA_BITS(24), .SIGN_EXTEND(0)) u_zf (
      .clk(clk), .rst(rst), .enable(enable), .resync(resync), .hold(hold),
      .in_valid(in_valid), .in_data(in_data), .in_ready(z_in_ready), .rd_ch(rd_ch),
      .rd_data(z_rd_data), .frame_count(z_frame_count), .frames_dropped(z_frames_dropped),
      .frame_done(z_frame_done), .partial(z_partial));

   adc_frame_snapshot #(.NUM_CH(1), .CH_IDX_W(4), .DATA_BITS(24), .SIGN_EXTEND(1)) u_sat (
      .clk(clk), .rst(rst), .enable(s_enable), .resync(s_resync), .hold(s_hold),
      .in_valid(s_valid), .in_data(s_data), .in_ready(s_in_ready), .rd_ch(s_rd_ch),
      .rd_data(s_rd_data), .frame_count(s_frame_count), .frames_dropped(s_frames_dropped),
      .frame_done(s_frame_done), .partial(s_partial));

   // Reference model: pending frame words in a queue, committed bank as arrays.
   logic [31:0] m_vis   [NCH];
   logic [31:0] m_vis_z [NCH];
   logic [31:0] m_words [$];
   logic [31:0] m_count;
   int          m_drop;
   logic        m_done, m_partial;
   logic [31:0] m_rd, m_rd_z;
   logic        rdy_seen, rdy_exp;

   int n_checks = 0;
   int n_fail   = 0;

   function automatic logic [31:0] ext24(input logic [31:0] w, input bit sx);
      logic [31:0] r;
      r = {8'h00, w[23:0]};
      if (sx && w[23]) r = r | 32'hFF00_0000;
      return r;
   endfunction

   // Advance one clock: sample in_ready, update the model, then let the edge happen.
   task automatic step();
      #1;
      rdy_seen = in_ready;
      rdy_exp  = enable && !resync && !rst;
      if (rst) begin
         m_words.delete();
         for (int i = 0; i < NCH; i++) begin m_vis[i] = 0; m_vis_z[i] = 0; end
         m_rd = 0; m_rd_z = 0; m_count = 0; m_drop = 0; m_done = 0; m_partial = 0;
      end else begin
         m_rd   = (rd_ch < NCH) ? m_vis[rd_ch]   : 32'd0;
         m_rd_z = (rd_ch < NCH) ? m_vis_z[rd_ch] : 32'd0;
         m_done = 0;
         if (resync) begin
            m_words.delete();
         end else if (in_valid && rdy_exp) begin
            m_words.push_back(in_data);
            if (m_words.size() == NCH) begin
               if (!hold) begin
                  for (int i = 0; i < NCH; i++) begin
                     m_vis[i]   = ext24(m_words[i], 1'b1);
                     m_vis_z[i] = ext24(m_words[i], 1'b0);
                  end
                  m_count = m_count + 32'd1;
                  m_done  = 1;
               end else if (m_drop < 65535) begin
                  m_drop++;
               end
               m_words.delete();
            end
         end
         m_partial = (m_words.size() != 0);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1; in_valid = 1; in_data = 32'h1234_5678;
      step(); step();
      n_checks++; if (rdy_seen !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", rdy_seen); end
      n_checks++; if (rd_data !== 32'd0) begin n_fail++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
      n_checks++; if (frame_count !== 32'd0) begin n_fail++; $display("FAIL reset_frame_count: got %0d want 0", frame_count); end
      n_checks++; if (frames_dropped !== 16'd0) begin n_fail++; $display("FAIL reset_dropped: got %0d want 0", frames_dropped); end
      n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
      n_checks++; if (partial !== 1'b0) begin n_fail++; $display("FAIL reset_partial: got %b want 0", partial); end
      rst = 0; in_valid = 0;
   endtask

   task automatic test_basic_commit();
      logic [31:0] w [3];
      logic [31:0] ev [4];
      logic [31:0] ez [4];
      w  = '{32'h0012_3456, 32'h0080_0001, 32'h007F_FFFF};
      ev = '{32'h0012_3456, 32'hFF80_0001, 32'h007F_FFFF, 32'h0};
      ez = '{32'h0012_3456, 32'h0080_0001, 32'h007F_FFFF, 32'h0};
      for (int i = 0; i < 3; i++) begin
         in_valid = 1; in_data = w[i];
         step();
         n_checks++; if (rdy_seen !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready: got %b want 1", rdy_seen); end
         n_checks++; if (partial !== (i != 2)) begin n_fail++; $display("FAIL basic_partial: got %b want %b", partial, (i != 2)); end
      end
      n_checks++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL basic_frame_done: got %b want 1", frame_done); end
      n_checks++; if (frame_count !== 32'd1) begin n_fail++; $display("FAIL basic_frame_count: got %0d want 1", frame_count); end
      in_valid = 0;
      for (int c = 0; c < 4; c++) begin
         rd_ch = 4'(c);
         step();
         if (c == 0) begin
            n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL basic_done_width: got %b want 0", frame_done); end
         end
         n_checks++; if (rd_data !== ev[c]) begin n_fail++; $display("FAIL basic_rd_ch%0d: got %h want %h", c, rd_data, ev[c]); end
         n_checks++; if (z_rd_data !== ez[c]) begin n_fail++; $display("FAIL zerofill_rd_ch%0d: got %h want %h", c, z_rd_data, ez[c]); end
      end
      rd_ch = 0;
   endtask

   task automatic test_back_to_back();
      logic [31:0] start;
      start = m_count;
      for (int f = 0; f < 4; f++) begin
         for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_data = $urandom;
            step();
            n_checks++; if (rdy_seen !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready: got %b want 1", rdy_seen); end
            n_checks++; if (partial !== m_partial) begin n_fail++; $display("FAIL b2b_partial: got %b want %b", partial, m_partial); end
            n_checks++; if (frame_done !== m_done) begin n_fail++; $display("FAIL b2b_frame_done: got %b want %b", frame_done, m_done); end
         end
      end
      in_valid = 0;
      n_checks++; if (frame_count !== start + 32'd4) begin n_fail++; $display("FAIL b2b_frame_count: got %0d want %0d", frame_count, start + 32'd4); end
      for (int c = 0; c < 3; c++) begin
         rd_ch = 4'(c); step();
         n_checks++; if (rd_data !== m_rd) begin n_fail++; $display("FAIL b2b_rd_ch%0d: got %h want %h", c, rd_data, m_rd); end
      end
   endtask

   task automatic test_hold_drop();
      logic [31:0] snap [NCH];
      logic [31:0] cnt0;
      int          drop0;
      for (int c = 0; c < NCH; c++) snap[c] = m_vis[c];
      cnt0 = m_count; drop0 = m_drop;
      hold = 1;
      for (int i = 0; i < 6; i++) begin
         in_valid = 1; in_data = $urandom;
         step();
         n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL hold_frame_done: got %b want 0", frame_done); end
      end
      in_valid = 0;
      n_checks++; if (frames_dropped !== 16'(drop0 + 2)) begin n_fail++; $display("FAIL hold_dropped: got %0d want %0d", frames_dropped, drop0 + 2); end
      n_checks++; if (frame_count !== cnt0) begin n_fail++; $display("FAIL hold_frame_count: got %0d want %0d", frame_count, cnt0); end
      for (int c = 0; c < NCH; c++) begin
         rd_ch = 4'(c); step();
         n_checks++; if (rd_data !== snap[c]) begin n_fail++; $display("FAIL hold_visible_ch%0d: got %h want %h", c, rd_data, snap[c]); end
      end
      // Hold only matters on the completing word.
      for (int i = 0; i < 3; i++) begin
         hold = (i != 2); in_valid = 1; in_data = $urandom;
         step();
      end
      in_valid = 0; hold = 0;
      n_checks++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL release_frame_done: got %b want 1", frame_done); end
      n_checks++; if (frame_count !== cnt0 + 32'd1) begin n_fail++; $display("FAIL release_frame_count: got %0d want %0d", frame_count, cnt0 + 32'd1); end
      for (int c = 0; c < NCH; c++) begin
         rd_ch = 4'(c); step();
         n_checks++; if (rd_data !== m_rd) begin n_fail++; $display("FAIL release_rd_ch%0d: got %h want %h", c, rd_data, m_rd); end
      end
   endtask

   task automatic test_resync();
      logic [31:0] w [3];
      for (int i = 0; i < 2; i++) begin in_valid = 1; in_data = $urandom; step(); end
      resync = 1; in_valid = 1; in_data = $urandom;
      step();
      n_checks++; if (rdy_seen !== 1'b0) begin n_fail++; $display("FAIL resync_in_ready: got %b want 0", rdy_seen); end
      n_checks++; if (partial !== 1'b0) begin n_fail++; $display("FAIL resync_partial: got %b want 0", partial); end
      resync = 0;
      for (int i = 0; i < 3; i++) begin w[i] = $urandom; in_valid = 1; in_data = w[i]; step(); end
      in_valid = 0;
      n_checks++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL resync_frame_done: got %b want 1", frame_done); end
      for (int c = 0; c < 3; c++) begin
         rd_ch = 4'(c); step();
         n_checks++; if (rd_data !== ext24(w[c], 1'b1)) begin n_fail++; $display("FAIL resync_rd_ch%0d: got %h want %h", c, rd_data, ext24(w[c], 1'b1)); end
      end
   endtask

   task automatic test_enable_gap();
      logic [31:0] w [3];
      w[0] = $urandom; in_valid = 1; in_data = w[0]; step();
      enable = 0;
      for (int i = 0; i < 10; i++) begin
         in_data = $urandom; step();
         n_checks++; if (rdy_seen !== 1'b0) begin n_fail++; $display("FAIL gap_in_ready: got %b want 0", rdy_seen); end
         n_checks++; if (partial !== 1'b1) begin n_fail++; $display("FAIL gap_partial: got %b want 1", partial); end
      end
      enable = 1;
      for (int i = 1; i < 3; i++) begin w[i] = $urandom; in_data = w[i]; step(); end
      in_valid = 0;
      n_checks++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL gap_frame_done: got %b want 1", frame_done); end
      for (int c = 0; c < 3; c++) begin
         rd_ch = 4'(c); step();
         n_checks++; if (rd_data !== ext24(w[c], 1'b1)) begin n_fail++; $display("FAIL gap_rd_ch%0d: got %h want %h", c, rd_data, ext24(w[c], 1'b1)); end
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 2; i++) begin in_valid = 1; in_data = $urandom; step(); end
      rst = 1; step(); rst = 0; in_valid = 0;
      n_checks++; if (frame_count !== 32'd0) begin n_fail++; $display("FAIL rstmid_frame_count: got %0d want 0", frame_count); end
      n_checks++; if (frames_dropped !== 16'd0) begin n_fail++; $display("FAIL rstmid_dropped: got %0d want 0", frames_dropped); end
      n_checks++; if (partial !== 1'b0) begin n_fail++; $display("FAIL rstmid_partial: got %b want 0", partial); end
      n_checks++; if (rd_data !== 32'd0) begin n_fail++; $display("FAIL rstmid_rd_data: got %h want 0", rd_data); end
      for (int c = 0; c < 3; c++) begin
         rd_ch = 4'(c); step();
         n_checks++; if (rd_data !== 32'd0) begin n_fail++; $display("FAIL rstmid_bank_ch%0d: got %h want 0", c, rd_data); end
      end
      for (int i = 0; i < 3; i++) begin in_valid = 1; in_data = $urandom; step(); end
      in_valid = 0;
      n_checks++; if (frame_count !== 32'd1) begin n_fail++; $display("FAIL rstmid_first_frame: got %0d want 1", frame_count); end
   endtask

   task automatic test_read_timing();
      logic [31:0] old_v, a;
      rd_ch = 0; step();
      old_v = m_vis[0];
      a = $urandom;
      if (ext24(a, 1'b1) == old_v) a = a ^ 32'd1;
      in_valid = 1; in_data = a; step();
      in_data = $urandom; step();
      in_data = $urandom; step();
      in_valid = 0;
      n_checks++; if (rd_data !== old_v) begin n_fail++; $display("FAIL rdtime_commit_edge: got %h want %h", rd_data, old_v); end
      step();
      n_checks++; if (rd_data !== ext24(a, 1'b1)) begin n_fail++; $display("FAIL rdtime_next_cycle: got %h want %h", rd_data, ext24(a, 1'b1)); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         enable   = ($urandom % 8) != 0;
         resync   = ($urandom % 16) == 0;
         hold     = ($urandom % 4) == 0;
         in_valid = ($urandom % 4) != 0;
         in_data  = $urandom;
         rd_ch    = 4'($urandom % 5);
         step();
         n_checks++; if (rdy_seen !== rdy_exp) begin n_fail++; $display("FAIL rand_in_ready @%0d: got %b want %b", n, rdy_seen, rdy_exp); end
         n_checks++; if (frame_count !== m_count) begin n_fail++; $display("FAIL rand_frame_count @%0d: got %0d want %0d", n, frame_count, m_count); end
         n_checks++; if (frames_dropped !== 16'(m_drop)) begin n_fail++; $display("FAIL rand_dropped @%0d: got %0d want %0d", n, frames_dropped, m_drop); end
         n_checks++; if (frame_done !== m_done) begin n_fail++; $display("FAIL rand_frame_done @%0d: got %b want %b", n, frame_done, m_done); end
         n_checks++; if (partial !== m_partial) begin n_fail++; $display("FAIL rand_partial @%0d: got %b want %b", n, partial, m_partial); end
         n_checks++; if (rd_data !== m_rd) begin n_fail++; $display("FAIL rand_rd_data @%0d: got %h want %h", n, rd_data, m_rd); end
         n_checks++; if (z_rd_data !== m_rd_z) begin n_fail++; $display("FAIL rand_zf_rd_data @%0d: got %h want %h", n, z_rd_data, m_rd_z); end
      end
      enable = 1; resync = 0; hold = 0; in_valid = 0; rd_ch = 0;
   endtask

   // NUM_CH=1: every accepted word is a frame, so drops climb one per cycle.
   task automatic test_saturation();
      s_hold = 1; s_valid = 1; s_data = $urandom;
      repeat (65534) @(posedge clk);
      #1;
      n_checks++; if (s_frames_dropped !== 16'hFFFE) begin n_fail++; $display("FAIL sat_pre: got %h want fffe", s_frames_dropped); end
      @(posedge clk); #1;
      n_checks++; if (s_frames_dropped !== 16'hFFFF) begin n_fail++; $display("FAIL sat_reach: got %h want ffff", s_frames_dropped); end
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (s_frames_dropped !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold: got %h want ffff", s_frames_dropped); end
      n_checks++; if (s_frame_count !== 32'd0) begin n_fail++; $display("FAIL sat_frame_count: got %0d want 0", s_frame_count); end
      s_hold = 0; s_data = 32'h00AB_CDEF; s_rd_ch = 0;
      @(posedge clk); #1;
      s_valid = 0;
      n_checks++; if (s_frame_done !== 1'b1) begin n_fail++; $display("FAIL single_frame_done: got %b want 1", s_frame_done); end
      n_checks++; if (s_frame_count !== 32'd1) begin n_fail++; $display("FAIL single_frame_count: got %0d want 1", s_frame_count); end
      @(posedge clk); #1;
      n_checks++; if (s_rd_data !== 32'hFFAB_CDEF) begin n_fail++; $display("FAIL single_rd_data: got %h want ffabcdef", s_rd_data); end
   endtask

   initial begin
      rst = 1; enable = 1; resync = 0; hold = 0; in_valid = 0; in_data = 0; rd_ch = 0;
      s_enable = 1; s_resync = 0; s_hold = 0; s_valid = 0; s_data = 0; s_rd_ch = 0;
      test_reset();
      test_basic_commit();
      test_back_to_back();
      test_hold_drop();
      test_resync();
      test_enable_gap();
      test_reset_mid();
      test_read_timing();
      test_random();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
